in_channel_controller: RTL and testbench

- Owns the VM input channel: buffers up to NIn words pushed by an external loader, then serves the core's `in` and `inSize` requests in order.
- Replaces the fixed inMem/inMemPos bookkeeping in the core with one sequenced resource.
- Sits between the host/loader stream and the instruction-execution core; one outstanding request stream, fixed 1-cycle response latency.

---
 rtl/vm_io_pkg.sv | 14 +
 rtl/in_channel_controller_if.sv | 34 +++
 rtl/channel_buffer.sv | 31 +++
 rtl/in_channel_controller.sv | 139 +++++++++++++
 tb/tb_in_channel_controller.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/vm_io_pkg.sv
// rtl/vm_io_pkg.sv - shared types and constants for the VM input/output channels
package vm_io_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic OP_IN_SIZE = 1'b0;
  localparam logic OP_IN      = 1'b1;

  localparam int DEFAULT_MEMORY_ELEMENT_WIDTH = 12;

endpackage

// File: rtl/in_channel_controller_if.sv
// rtl/in_channel_controller_if.sv - loader, control and core request/response bundle of the input channel
interface in_channel_controller_if #(
  parameter int MemoryElementWidth = vm_io_pkg::DEFAULT_MEMORY_ELEMENT_WIDTH,
  parameter int NIn                = 2
);
  localparam int CountWidth = $clog2(NIn + 1);

  logic                          loadValid;
  logic [MemoryElementWidth-1:0] loadData;
  logic                          loadLast;
  logic                          loadReady;
  logic                          start;
  logic                          reload;
  logic                          rewind;
  logic                          reqValid;
  logic                          reqOp;
  logic                          reqReady;
  logic                          rspValid;
  logic [MemoryElementWidth-1:0] rspData;
  logic                          rspEmpty;
  logic [CountWidth-1:0]         remaining;
  logic                          serving;

  modport master (
    output loadValid, loadData, loadLast, start, reload, rewind, reqValid, reqOp,
    input  loadReady, reqReady, rspValid, rspData, rspEmpty, remaining, serving
  );

  modport slave (
    input  loadValid, loadData, loadLast, start, reload, rewind, reqValid, reqOp,
    output loadReady, reqReady, rspValid, rspData, rspEmpty, remaining, serving
  );

endinterface

// File: rtl/channel_buffer.sv
// rtl/channel_buffer.sv - NIn-word register file, one write port and one asynchronous read port
module channel_buffer #(
  parameter int Width     = 12,
  parameter int Depth     = 2,
  parameter int AddrWidth = 2
) (
  input  logic                 clock,
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [Width-1:0]     wr_data,
  input  logic [AddrWidth-1:0] rd_addr,
  output logic [Width-1:0]     rd_data
);

  logic [Width-1:0] mem [Depth];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clock) begin
    if (wr_en && (wr_addr < AddrWidth'(Depth))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr < AddrWidth'(Depth)) begin
      rd_data = mem[rd_addr];
    end
  end

endmodule

// File: rtl/in_channel_controller.sv
// rtl/in_channel_controller.sv - buffers loader words, then serves the core's in/inSize requests in order
module in_channel_controller
  import vm_io_pkg::*;
#(
  parameter int MemoryElementWidth = DEFAULT_MEMORY_ELEMENT_WIDTH,
  parameter int NIn                = 2
) (
  input  logic                    clock,
  input  logic                    resetN,
  in_channel_controller_if.slave  bus
);

  localparam int CountWidth = $clog2(NIn + 1);
  localparam logic [CountWidth-1:0] CapLimit = CountWidth'(NIn);

  state_t                        state_q, state_d;
  logic [CountWidth-1:0]         count_q, count_d;
  logic [CountWidth-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0]         remaining_q;
  logic                          pend_q, pend_d;
  logic                          pend_op_q, pend_op_d;
  logic                          wr_en;
  logic                          load_ready;
  logic                          req_ready;
  logic                          have_word;
  logic [MemoryElementWidth-1:0] rd_word;

  channel_buffer #(
    .Width     (MemoryElementWidth),
    .Depth     (NIn),
    .AddrWidth (CountWidth)
  ) u_buffer (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (count_q),
    .wr_data (bus.loadData),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_word)
  );

  // An accepted request is resolved in the following cycle against the
  // registered pointer, so a rewind lands before the request it accompanies.
  assign have_word = rd_ptr_q < count_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= LOAD;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      pend_q      <= 1'b0;
      pend_op_q   <= OP_IN_SIZE;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= count_q - rd_ptr_q;
      pend_q      <= pend_d;
      pend_op_q   <= pend_op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    pend_d     = 1'b0;
    pend_op_d  = pend_op_q;
    wr_en      = 1'b0;
    load_ready = 1'b0;
    req_ready  = 1'b0;

    // The response being presented now consumes a word before anything newer.
    if (pend_q && (pend_op_q == OP_IN) && have_word) begin
      rd_ptr_d = rd_ptr_q + CountWidth'(1);
    end

    unique case (state_q)
      LOAD: begin
        load_ready = !bus.reload && (count_q < CapLimit);
        if (bus.reload) begin
          count_d  = '0;
          rd_ptr_d = '0;
        end else begin
          if (bus.loadValid && load_ready) begin
            wr_en   = 1'b1;
            count_d = count_q + CountWidth'(1);
            if (bus.loadLast || (count_q + CountWidth'(1) == CapLimit)) begin
              state_d = SERVE;
            end
          end
          if (bus.start) begin
            state_d = SERVE;
          end
        end
      end
      SERVE: begin
        req_ready = !bus.reload;
        if (bus.reload) begin
          state_d  = LOAD;
          count_d  = '0;
          rd_ptr_d = '0;
        end else begin
          if (bus.rewind) begin
            rd_ptr_d = '0;
          end
          if (bus.reqValid) begin
            pend_d    = 1'b1;
            pend_op_d = bus.reqOp;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_comb begin
    bus.rspData  = '0;
    bus.rspEmpty = 1'b0;
    if (pend_q) begin
      if (pend_op_q == OP_IN_SIZE) begin
        bus.rspData = MemoryElementWidth'(count_q - rd_ptr_q);
      end else if (have_word) begin
        bus.rspData = rd_word;
      end else begin
        bus.rspEmpty = 1'b1;
      end
    end
  end

  assign bus.rspValid  = pend_q;
  assign bus.loadReady = load_ready;
  assign bus.reqReady  = req_ready;
  assign bus.remaining = remaining_q;
  assign bus.serving   = (state_q == SERVE);

endmodule

// File: tb/tb_in_channel_controller.sv
// tb/tb_in_channel_controller.sv - scoreboard bench for in_channel_controller
module tb_in_channel_controller;
  import vm_io_pkg::*;

  localparam int W   = 12;
  localparam int N   = 2;
  localparam int CW  = $clog2(N + 1);

  logic clock  = 1'b0;
  logic resetN = 1'b0;

  in_channel_controller_if #(.MemoryElementWidth(W), .NIn(N)) bus ();

  in_channel_controller #(.MemoryElementWidth(W), .NIn(N)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int rsp_seen = 0;
  int rsp_pushed = 0;

  logic [W:0] sb [$];

  logic [W-1:0] m_mem [N];
  int           m_count;
  int           m_rd;
  bit           m_serving;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (resetN && bus.rspValid) begin
      logic [W:0] e;
      rsp_seen++;
      check_eq("rsp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("rsp_data", 32'(bus.rspData), 32'(e[W-1:0]));
        check_eq("rsp_empty", 32'(bus.rspEmpty), 32'(e[W]));
      end
    end
  end

  task automatic model_reset();
    m_count   = 0;
    m_rd      = 0;
    m_serving = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    bus.loadValid = 0; bus.loadData = '0; bus.loadLast = 0; bus.start = 0;
    bus.reload = 0; bus.rewind = 0; bus.reqValid = 0; bus.reqOp = 0;
    resetN = 1'b0;
    sb.delete();
    model_reset();
    idle(2);
    resetN = 1'b1;
    idle(1);
  endtask

  task automatic load_word(input logic [W-1:0] d, input bit last);
    bit exp_ready;
    bus.loadValid = 1; bus.loadData = d; bus.loadLast = last;
    @(negedge clock);
    exp_ready = !m_serving && (m_count < N);
    check_eq("load_ready", 32'(bus.loadReady), 32'(exp_ready));
    if (exp_ready) begin
      m_mem[m_count] = d;
      m_count++;
      if (last || m_count == N) m_serving = 1'b1;
    end
    @(posedge clock); #1;
    bus.loadValid = 0; bus.loadLast = 0;
  endtask

  task automatic pulse_start();
    bus.start = 1;
    @(posedge clock); #1;
    bus.start = 0;
    m_serving = 1'b1;
  endtask

  task automatic request(input logic op, input bit rew, input bit rel);
    bus.reqValid = 1; bus.reqOp = op; bus.rewind = rew; bus.reload = rel;
    @(negedge clock);
    check_eq("req_ready", 32'(bus.reqReady), 32'(m_serving && !rel));
    if (rel) begin
      m_serving = 1'b0; m_count = 0; m_rd = 0;
    end else if (m_serving) begin
      if (rew) m_rd = 0;
      rsp_pushed++;
      if (op == OP_IN_SIZE) begin
        sb.push_back({1'b0, W'(m_count - m_rd)});
      end else if (m_rd < m_count) begin
        sb.push_back({1'b0, m_mem[m_rd]});
        m_rd++;
      end else begin
        sb.push_back({1'b1, W'(0)});
      end
    end
    @(posedge clock); #1;
    bus.reqValid = 0; bus.rewind = 0; bus.reload = 0;
  endtask

  initial begin
    int base;
    bit seen2;
    apply_reset();

    resetN = 1'b0; #1;
    check_eq("rst_rsp_valid", 32'(bus.rspValid), 0);
    check_eq("rst_rsp_data", 32'(bus.rspData), 0);
    check_eq("rst_rsp_empty", 32'(bus.rspEmpty), 0);
    check_eq("rst_serving", 32'(bus.serving), 0);
    check_eq("rst_remaining", 32'(bus.remaining), 0);
    check_eq("rst_load_ready", 32'(bus.loadReady), 1);
    idle(1);
    resetN = 1'b1;
    idle(1);

    // Ordered mix of inSize and in: 2, 88, 1, 44, 0
    load_word(12'd88, 0);
    load_word(12'd44, 1);
    check_eq("t1_serving", 32'(bus.serving), 1);
    request(OP_IN_SIZE, 0, 0);
    request(OP_IN, 0, 0);
    request(OP_IN_SIZE, 0, 0);
    request(OP_IN, 0, 0);
    request(OP_IN_SIZE, 0, 0);
    idle(2);

    // Fill to capacity without loadLast, then read past the end
    apply_reset();
    load_word(12'd88, 0);
    load_word(12'd44, 0);
    load_word(12'd77, 0);
    check_eq("t2_serving", 32'(bus.serving), 1);
    request(OP_IN, 0, 0);
    request(OP_IN, 0, 0);
    request(OP_IN, 0, 0);
    idle(3);
    check_eq("t2_remaining", 32'(bus.remaining), 0);

    // Early start with one word, then back-to-back requests
    apply_reset();
    load_word(12'd5, 0);
    check_eq("t3_not_serving", 32'(bus.serving), 0);
    pulse_start();
    request(OP_IN, 0, 0);
    request(OP_IN, 0, 0);
    idle(2);
    base = rsp_seen;
    request(OP_IN_SIZE, 0, 0);
    request(OP_IN, 0, 0);
    request(OP_IN_SIZE, 0, 0);
    idle(2);
    check_eq("t3_pulses", 32'(rsp_seen - base), 3);

    // Rewind together with an in request
    apply_reset();
    load_word(12'd88, 0);
    load_word(12'd44, 1);
    request(OP_IN, 0, 0);
    idle(3);
    check_eq("t4_remaining_before", 32'(bus.remaining), 1);
    request(OP_IN, 1, 0);
    seen2 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus.remaining == CW'(2)) seen2 = 1;
    end
    check_eq("t4_remaining_seen2", 32'(seen2), 1);
    check_eq("t4_remaining_after", 32'(bus.remaining), 1);
    idle(1);

    // Reload wins over a request
    request(OP_IN, 0, 1);
    @(negedge clock);
    check_eq("t5_load_ready", 32'(bus.loadReady), 1);
    check_eq("t5_serving", 32'(bus.serving), 0);
    idle(2);
    check_eq("t5_remaining", 32'(bus.remaining), 0);
    load_word(12'd300, 1);
    request(OP_IN_SIZE, 0, 0);
    request(OP_IN, 0, 0);
    idle(2);

    // Asynchronous reset with a response in flight
    request(OP_IN_SIZE, 0, 0);
    check_eq("t6_pending", 32'(bus.rspValid), 1);
    resetN = 1'b0; #1;
    sb.delete();
    rsp_pushed--;
    model_reset();
    check_eq("t6_rsp_valid", 32'(bus.rspValid), 0);
    check_eq("t6_serving", 32'(bus.serving), 0);
    check_eq("t6_remaining", 32'(bus.remaining), 0);
    idle(1);
    resetN = 1'b1;
    idle(2);

    check_eq("sb_drained", 32'(sb.size()), 0);
    check_eq("rsp_count", 32'(rsp_seen), 32'(rsp_pushed));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
